// File: rtl/serializer_10b_if.sv
// Word-side handshake between the 8b/10b encoder (master) and the serializer (slave).
// data_ready is driven by the slave and depends only on its holding-buffer state.
interface serializer_10b_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] data_10b_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_10b_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_10b_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serializer_10b.sv
// Parallel-to-serial stage behind the 8b/10b encoder: one-word holding buffer feeding
// a shift register that emits one bit per clock, streaming words back-to-back when fed.
module serializer_10b #(
    parameter int WIDTH      = 10,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    serializer_10b_if.slave  word_if,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             underrun
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  hold_q;
    logic              hold_full_q;
    logic [WIDTH-1:0]  shift_q;
    logic [CW-1:0]     bit_cnt_q;
    logic              ser_out_q;
    logic              ser_valid_q;
    logic              frame_start_q;
    logic              underrun_q;

    logic              accept_s;
    logic              at_last_s;
    logic              load_s;

    // The next bit to transmit always sits at the head of the word, so load and shift share these.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign accept_s  = word_if.data_valid & ~hold_full_q;
    assign at_last_s = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign load_s    = hold_full_q & ((state_q == ST_IDLE) | at_last_s);

    assign word_if.data_ready = ~hold_full_q;
    assign ser_out            = ser_out_q;
    assign ser_valid          = ser_valid_q;
    assign frame_start        = frame_start_q;
    assign underrun           = underrun_q;

    // Holding buffer: filled on accept, emptied on load (the two are mutually exclusive).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (accept_s) begin
            hold_q      <= word_if.data_10b_in;
            hold_full_q <= 1'b1;
        end else if (load_s) begin
            hold_full_q <= 1'b0;
        end
    end

    // Shift FSM with registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else if (load_s) begin
            state_q       <= ST_SHIFT;
            ser_out_q     <= head_bit(hold_q);
            shift_q       <= drop_head(hold_q);
            bit_cnt_q     <= '0;
            ser_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            underrun_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    frame_start_q <= 1'b0;
                    if (bit_cnt_q != LAST_BIT) begin
                        ser_out_q   <= head_bit(shift_q);
                        shift_q     <= drop_head(shift_q);
                        bit_cnt_q   <= bit_cnt_q + CW'(1);
                        ser_valid_q <= 1'b1;
                        underrun_q  <= 1'b0;
                    end else begin
                        // Last bit sent and nothing buffered: drop to idle and flag the gap.
                        state_q     <= ST_IDLE;
                        ser_out_q   <= IDLE_LEVEL;
                        ser_valid_q <= 1'b0;
                        bit_cnt_q   <= '0;
                        underrun_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    ser_out_q     <= IDLE_LEVEL;
                    ser_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    underrun_q    <= 1'b0;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    ser_out_q     <= IDLE_LEVEL;
                    ser_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    underrun_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serializer_10b.sv
// Directed bench for serializer_10b: an LSB-first and an MSB-first instance, one task per scenario.
module tb_serializer_10b;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    serializer_10b_if #(.WIDTH(10)) lsb_if ();
    serializer_10b_if #(.WIDTH(10)) msb_if ();

    logic so0, sv0, fs0, ur0;
    logic so1, sv1, fs1, ur1;

    serializer_10b #(.WIDTH(10), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .word_if(lsb_if.slave),
        .ser_out(so0), .ser_valid(sv0), .frame_start(fs0), .underrun(ur0)
    );

    serializer_10b #(.WIDTH(10), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .word_if(msb_if.slave),
        .ser_out(so1), .ser_valid(sv1), .frame_start(fs1), .underrun(ur1)
    );

    bit   sel = 1'b0;
    logic cur_out, cur_valid, cur_fs, cur_ur, cur_ready;
    assign cur_out   = sel ? so1 : so0;
    assign cur_valid = sel ? sv1 : sv0;
    assign cur_fs    = sel ? fs1 : fs0;
    assign cur_ur    = sel ? ur1 : ur0;
    assign cur_ready = sel ? msb_if.data_ready : lsb_if.data_ready;

    int   checks = 0;
    int   errors = 0;
    logic rec_out[64], rec_valid[64], rec_fs[64], rec_ur[64], rec_ready[64];
    int   acc_cyc[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic v, input logic [9:0] d);
        if (s) begin
            msb_if.data_valid  = v;
            msb_if.data_10b_in = d;
        end else begin
            lsb_if.data_valid  = v;
            lsb_if.data_10b_in = d;
        end
    endtask

    // Offer up to three words in order (word 1 not before cycle st1) and record outputs after each edge c.
    task automatic stream(input bit s, input int n, input logic [9:0] w0, input logic [9:0] w1,
                          input logic [9:0] w2, input int st1, input int ncyc);
        logic [9:0] w[4];
        int   idx;
        logic vld, rdy;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = 10'd0;
        idx = 0;
        for (int k = 0; k < 3; k++) acc_cyc[k] = -1;
        sel = s;
        for (int c = 0; c < ncyc; c++) begin
            vld = (idx < n) && (idx != 1 || c >= st1);
            drive(s, vld, w[idx]);
            rdy = cur_ready;
            tick();
            rec_out[c] = cur_out; rec_valid[c] = cur_valid; rec_fs[c] = cur_fs;
            rec_ur[c] = cur_ur; rec_ready[c] = cur_ready;
            if (vld && rdy) begin
                acc_cyc[idx] = c;
                idx++;
            end
        end
        drive(s, 1'b0, 10'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'd0);
        drive(1'b1, 1'b0, 10'd0);
        #12;
        checks++; if (so0 !== 1'b0) begin errors++; $display("FAIL reset_ser_out got %b expected 0", so0); end
        checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL reset_ser_valid got %b expected 0", sv0); end
        checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b expected 0", fs0); end
        checks++; if (ur0 !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b expected 0", ur0); end
        checks++; if (lsb_if.data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready got %b expected 1", lsb_if.data_ready); end
        checks++; if (sv1 !== 1'b0 || so1 !== 1'b0) begin errors++; $display("FAIL reset_msb_line got %b%b expected 00", sv1, so1); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        logic e[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int vcnt = 0, fcnt = 0, ucnt = 0;
        stream(1'b0, 1, 10'b0100011000, 10'd0, 10'd0, 0, 14);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rec_out[1+i] !== e[i] || rec_valid[1+i] !== 1'b1) begin
                errors++; $display("FAIL single_bit%0d got %b/v%b expected %b/v1", i, rec_out[1+i], rec_valid[1+i], e[i]);
            end
        end
        for (int c = 0; c < 14; c++) begin
            vcnt += (rec_valid[c] === 1'b1) ? 1 : 0;
            fcnt += (rec_fs[c] === 1'b1) ? 1 : 0;
            ucnt += (rec_ur[c] === 1'b1) ? 1 : 0;
        end
        checks++; if (vcnt != 10) begin errors++; $display("FAIL single_valid_cnt got %0d expected 10", vcnt); end
        checks++; if (rec_fs[1] !== 1'b1 || fcnt != 1) begin errors++; $display("FAIL single_frame_start got %b cnt %0d expected 1 cnt 1", rec_fs[1], fcnt); end
        checks++; if (rec_ur[11] !== 1'b1 || ucnt != 1) begin errors++; $display("FAIL single_underrun got %b cnt %0d expected 1 cnt 1", rec_ur[11], ucnt); end
        checks++; if (rec_out[11] !== 1'b0 || rec_out[12] !== 1'b0) begin errors++; $display("FAIL single_idle_line got %b%b expected 00", rec_out[11], rec_out[12]); end
        checks++; if (rec_ready[0] !== 1'b0 || rec_ready[1] !== 1'b1) begin errors++; $display("FAIL single_ready got %b%b expected 01", rec_ready[0], rec_ready[1]); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp_stream = {10'h0F0, 10'h15A, 10'h3A5};
        int lowcnt = 0, ucnt = 0;
        stream(1'b0, 3, 10'h3A5, 10'h15A, 10'h0F0, 0, 40);
        checks++; if (acc_cyc[0] != 0 || acc_cyc[1] != 2 || acc_cyc[2] != 12) begin
            errors++; $display("FAIL b2b_accepts got %0d,%0d,%0d expected 0,2,12", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if (rec_valid[c] !== 1'b1 || rec_out[c] !== exp_stream[c-1] || rec_fs[c] !== ((c % 10) == 1)) begin
                errors++; $display("FAIL b2b_cycle%0d got v%b d%b f%b expected v1 d%b f%b", c, rec_valid[c], rec_out[c], rec_fs[c], exp_stream[c-1], (c % 10) == 1);
            end
        end
        for (int c = 0; c < 40; c++) begin
            lowcnt += (rec_ready[c] === 1'b0) ? 1 : 0;
            ucnt   += (rec_ur[c] === 1'b1) ? 1 : 0;
        end
        checks++; if (rec_valid[31] !== 1'b0 || rec_ur[31] !== 1'b1 || ucnt != 1) begin
            errors++; $display("FAIL b2b_end got v%b u%b ucnt %0d expected v0 u1 ucnt 1", rec_valid[31], rec_ur[31], ucnt);
        end
        checks++; if (lowcnt != 19) begin errors++; $display("FAIL b2b_ready_low got %0d expected 19", lowcnt); end
    endtask

    task automatic test_msb_first();
        logic e1[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e2[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        stream(1'b1, 1, 10'b1000000001, 10'd0, 10'd0, 0, 13);
        for (int i = 0; i < 10; i++) begin
            checks++; if (rec_out[1+i] !== e1[i]) begin errors++; $display("FAIL msb_w1_bit%0d got %b expected %b", i, rec_out[1+i], e1[i]); end
        end
        checks++; if (rec_fs[1] !== 1'b1 || rec_ur[11] !== 1'b1) begin errors++; $display("FAIL msb_w1_frame got f%b u%b expected f1 u1", rec_fs[1], rec_ur[11]); end
        stream(1'b1, 1, 10'b1100000000, 10'd0, 10'd0, 0, 13);
        for (int i = 0; i < 10; i++) begin
            checks++; if (rec_out[1+i] !== e2[i]) begin errors++; $display("FAIL msb_w2_bit%0d got %b expected %b", i, rec_out[1+i], e2[i]); end
        end
        sel = 1'b0;
    endtask

    task automatic test_buffer_full();
        logic [29:0] exp_stream = {10'h2AA, 10'h0F5, 10'h1C3};
        int vcnt = 0;
        stream(1'b0, 3, 10'h1C3, 10'h0F5, 10'h2AA, 0, 40);
        checks++; if (acc_cyc[1] != 2 || acc_cyc[2] != 12) begin
            errors++; $display("FAIL full_accepts got %0d,%0d expected 2,12", acc_cyc[1], acc_cyc[2]);
        end
        for (int c = 2; c <= 10; c++) begin
            checks++; if (rec_ready[c] !== 1'b0) begin errors++; $display("FAIL full_ready_c%0d got %b expected 0", c, rec_ready[c]); end
        end
        for (int c = 1; c <= 30; c++) begin
            checks++; if (rec_out[c] !== exp_stream[c-1]) begin errors++; $display("FAIL full_bit_c%0d got %b expected %b", c, rec_out[c], exp_stream[c-1]); end
        end
        for (int c = 0; c < 40; c++) vcnt += (rec_valid[c] === 1'b1) ? 1 : 0;
        checks++; if (vcnt != 30) begin errors++; $display("FAIL full_valid_cnt got %0d expected 30", vcnt); end
    endtask

    task automatic test_reset_mid_word();
        logic e[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int seen = 0;
        sel = 1'b0;
        drive(1'b0, 1'b1, 10'h3C3);
        tick();
        drive(1'b0, 1'b1, 10'h0AB);
        tick();
        tick();
        drive(1'b0, 1'b0, 10'd0);
        tick(); tick(); tick();
        checks++; if (sv0 !== 1'b1 || lsb_if.data_ready !== 1'b0) begin
            errors++; $display("FAIL rst_pre got v%b r%b expected v1 r0", sv0, lsb_if.data_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (sv0 !== 1'b0 || so0 !== 1'b0 || lsb_if.data_ready !== 1'b1 || fs0 !== 1'b0 || ur0 !== 1'b0) begin
            errors++; $display("FAIL rst_async got v%b d%b r%b f%b u%b expected v0 d0 r1 f0 u0", sv0, so0, lsb_if.data_ready, fs0, ur0);
        end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            seen += (sv0 !== 1'b0 || ur0 !== 1'b0) ? 1 : 0;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_discard got %0d active cycles expected 0", seen); end
        stream(1'b0, 1, 10'h0C7, 10'd0, 10'd0, 0, 13);
        for (int i = 0; i < 10; i++) begin
            checks++; if (rec_out[1+i] !== e[i] || rec_valid[1+i] !== 1'b1) begin
                errors++; $display("FAIL rst_new_bit%0d got %b/v%b expected %b/v1", i, rec_out[1+i], rec_valid[1+i], e[i]);
            end
        end
    endtask

    task automatic test_late_feed();
        logic e[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        stream(1'b0, 2, 10'h155, 10'h2B3, 10'd0, 11, 26);
        checks++; if (acc_cyc[1] != 11) begin errors++; $display("FAIL late_accept got %0d expected 11", acc_cyc[1]); end
        checks++; if (rec_ur[11] !== 1'b1 || rec_valid[11] !== 1'b0 || rec_out[11] !== 1'b0 || rec_ready[11] !== 1'b0) begin
            errors++; $display("FAIL late_gap got u%b v%b d%b r%b expected u1 v0 d0 r0", rec_ur[11], rec_valid[11], rec_out[11], rec_ready[11]);
        end
        checks++; if (rec_fs[12] !== 1'b1 || rec_valid[12] !== 1'b1 || rec_ur[12] !== 1'b0) begin
            errors++; $display("FAIL late_restart got f%b v%b u%b expected f1 v1 u0", rec_fs[12], rec_valid[12], rec_ur[12]);
        end
        for (int i = 0; i < 10; i++) begin
            checks++; if (rec_out[12+i] !== e[i]) begin errors++; $display("FAIL late_bit%0d got %b expected %b", i, rec_out[12+i], e[i]); end
        end
        checks++; if (rec_ur[22] !== 1'b1) begin errors++; $display("FAIL late_end_underrun got %b expected 1", rec_ur[22]); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_msb_first();
        test_buffer_full();
        test_reset_mid_word();
        test_late_feed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
